integer_file: RTL and testbench

INTEGER_FILE -- requirements
Module: integer_file

---
 rtl/integer_file.sv | 71 +++++++
 tb/tb_integer_file.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_file.sv
// Integer register file: two combinational read ports, one write port, committed-write counter.
// Optional same-cycle write-to-read forwarding is enabled by defining INTEGER_FILE_BYPASS_EN.
module integer_file #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] rs1_addr_in,
  input  logic [ADDR_W-1:0] rs2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic              flush_in,
  input  logic [XLEN-1:0]   rd_in,
  output logic [XLEN-1:0]   rs1_out,
  output logic [XLEN-1:0]   rs2_out,
  output logic [15:0]       wr_count_out
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 16;

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] wr_count_d;
  logic             commit_c;

  // A write commits only outside reset, unflushed, and never to x0
  always_comb begin
    commit_c = rst_in && wr_en_in && !flush_in && (rd_addr_in != '0);
  end

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit_c) begin
      regs_d[rd_addr_in] = rd_in;
      wr_count_d         = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports; x0 is hard-wired to zero
  always_comb begin
    rs1_out = (rs1_addr_in == '0) ? '0 : regs_q[rs1_addr_in];
    rs2_out = (rs2_addr_in == '0) ? '0 : regs_q[rs2_addr_in];
`ifdef INTEGER_FILE_BYPASS_EN
    if (commit_c && (rd_addr_in == rs1_addr_in)) begin
      rs1_out = rd_in;
    end
    if (commit_c && (rd_addr_in == rs2_addr_in)) begin
      rs2_out = rd_in;
    end
`endif
  end

  assign wr_count_out = wr_count_q;

endmodule

// File: tb/tb_integer_file.sv
// Self-checking bench for integer_file against an array-based reference model.
// Follows INTEGER_FILE_BYPASS_EN to pick the expected same-cycle read behaviour.
module tb_integer_file;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [4:0]  rs1_addr_in = '0;
  logic [4:0]  rs2_addr_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        wr_en_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [31:0] rd_in = '0;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;
  logic [15:0] wr_count_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl_regs [32];
  int unsigned mdl_cnt;

  integer_file #(.XLEN(32), .ADDR_W(5)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rs1_addr_in  (rs1_addr_in),
    .rs2_addr_in  (rs2_addr_in),
    .rd_addr_in   (rd_addr_in),
    .wr_en_in     (wr_en_in),
    .flush_in     (flush_in),
    .rd_in        (rd_in),
    .rs1_out      (rs1_out),
    .rs2_out      (rs2_out),
    .wr_count_out (wr_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Expected read value for an address given the registers and the inputs of this cycle
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef INTEGER_FILE_BYPASS_EN
    if (rst_in && wr_en_in && !flush_in && rd_addr_in == a) return rd_in;
`endif
    return mdl_regs[a];
  endfunction

  // Advance one clock edge, applying the architectural rules to the model
  task automatic step();
    @(posedge clk_in);
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
      mdl_cnt = 0;
    end else if (wr_en_in && !flush_in && rd_addr_in != 5'd0) begin
      mdl_regs[rd_addr_in] = rd_in;
      mdl_cnt = (mdl_cnt + 1) % 65536;
    end
    #1;
  endtask

  task automatic idle();
    wr_en_in = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic fl);
    rd_addr_in = a;
    rd_in      = d;
    wr_en_in   = 1'b1;
    flush_in   = fl;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    wr_en_in = 1'b1;
    rd_addr_in = 5'd2;
    rd_in = 32'hFFFF_0000;
    step();
    step();
    idle();
    rst_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr_in = 5'(i);
      rs2_addr_in = 5'(31 - i);
      #1;
      checks++;
      if (rs1_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_rs1[%0d]: got %h exp %h", i, rs1_out, 32'h0);
      end
      checks++;
      if (rs2_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_rs2[%0d]: got %h exp %h", 31 - i, rs2_out, 32'h0);
      end
    end
    checks++;
    if (wr_count_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_count: got %h exp %h", wr_count_out, 16'h0);
    end
  endtask

  task automatic test_basic();
    write(5'd5, 32'hDEAD_BEEF, 1'b0);
    rs1_addr_in = 5'd5;
    rs2_addr_in = 5'd5;
    #1;
    checks++;
    if (rs1_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_rs1: got %h exp %h", rs1_out, 32'hDEAD_BEEF);
    end
    checks++;
    if (rs2_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_rs2: got %h exp %h", rs2_out, 32'hDEAD_BEEF);
    end
    checks++;
    if (wr_count_out !== 16'd1) begin
      errors++;
      $display("FAIL basic_count: got %h exp %h", wr_count_out, 16'd1);
    end
  endtask

  task automatic test_gated();
    logic [15:0] cnt_before;
    cnt_before = wr_count_out;
    write(5'd0, 32'h1234_5678, 1'b0);
    write(5'd7, 32'hA5A5_A5A5, 1'b1);
    rs1_addr_in = 5'd0;
    rs2_addr_in = 5'd7;
    #1;
    checks++;
    if (rs1_out !== 32'h0) begin
      errors++;
      $display("FAIL gated_x0: got %h exp %h", rs1_out, 32'h0);
    end
    checks++;
    if (rs2_out !== 32'h0) begin
      errors++;
      $display("FAIL gated_x7: got %h exp %h", rs2_out, 32'h0);
    end
    checks++;
    if (wr_count_out !== cnt_before) begin
      errors++;
      $display("FAIL gated_count: got %h exp %h", wr_count_out, cnt_before);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] exp_now;
    write(5'd9, 32'h1111_1111, 1'b0);
    rs1_addr_in = 5'd9;
    rs2_addr_in = 5'd3;
    rd_addr_in  = 5'd9;
    rd_in       = 32'h2222_2222;
    wr_en_in    = 1'b1;
    flush_in    = 1'b0;
    #1;
`ifdef INTEGER_FILE_BYPASS_EN
    exp_now = 32'h2222_2222;
`else
    exp_now = 32'h1111_1111;
`endif
    checks++;
    if (rs1_out !== exp_now) begin
      errors++;
      $display("FAIL hazard_same_cycle: got %h exp %h", rs1_out, exp_now);
    end
    step();
    idle();
    #1;
    checks++;
    if (rs1_out !== 32'h2222_2222) begin
      errors++;
      $display("FAIL hazard_next_cycle: got %h exp %h", rs1_out, 32'h2222_2222);
    end
    // flushed same-cycle write to a read address must never forward
    rd_in = 32'h3333_3333;
    wr_en_in = 1'b1;
    flush_in = 1'b1;
    #1;
    checks++;
    if (rs1_out !== 32'h2222_2222) begin
      errors++;
      $display("FAIL hazard_flush_fwd: got %h exp %h", rs1_out, 32'h2222_2222);
    end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    write(5'd3, 32'h0000_FFFF, 1'b0);
    write(5'd4, 32'h0000_0001, 1'b0);
    rst_in = 1'b0;
    rd_addr_in = 5'd6;
    rd_in = 32'hCAFE_BABE;
    wr_en_in = 1'b1;
    rs1_addr_in = 5'd6;
    step();
    idle();
    rst_in = 1'b1;
    for (int a = 3; a <= 6; a++) begin
      if (a == 5) continue;
      rs1_addr_in = 5'(a);
      #1;
      checks++;
      if (rs1_out !== 32'h0) begin
        errors++;
        $display("FAIL resetmid_x%0d: got %h exp %h", a, rs1_out, 32'h0);
      end
    end
    checks++;
    if (wr_count_out !== 16'h0) begin
      errors++;
      $display("FAIL resetmid_count: got %h exp %h", wr_count_out, 16'h0);
    end
    // first cycle out of reset accepts a write
    write(5'd6, 32'h0BAD_F00D, 1'b0);
    rs2_addr_in = 5'd6;
    #1;
    checks++;
    if (rs2_out !== 32'h0BAD_F00D || wr_count_out !== 16'd1) begin
      errors++;
      $display("FAIL resetmid_post_write: got %h/%h exp %h/%h", rs2_out, wr_count_out, 32'h0BAD_F00D, 16'd1);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      rst_in      = ($urandom_range(0, 24) != 0);
      wr_en_in    = ($urandom_range(0, 3) != 0);
      flush_in    = ($urandom_range(0, 5) == 0);
      rd_addr_in  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd_in       = $urandom;
      rs1_addr_in = ($urandom_range(0, 2) == 0) ? rd_addr_in : 5'($urandom_range(0, 31));
      rs2_addr_in = ($urandom_range(0, 3) == 0) ? rs1_addr_in : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_rd(rs1_addr_in);
      e2 = exp_rd(rs2_addr_in);
      checks++;
      if (rs1_out !== e1) begin
        errors++;
        $display("FAIL rand_rs1[%0d] a=%0d: got %h exp %h", n, rs1_addr_in, rs1_out, e1);
      end
      checks++;
      if (rs2_out !== e2) begin
        errors++;
        $display("FAIL rand_rs2[%0d] a=%0d: got %h exp %h", n, rs2_addr_in, rs2_out, e2);
      end
      checks++;
      if (wr_count_out !== 16'(mdl_cnt)) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %h exp %h", n, wr_count_out, 16'(mdl_cnt));
      end
      step();
    end
    idle();
    rst_in = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] last;
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    rd_addr_in = 5'd1;
    wr_en_in = 1'b1;
    flush_in = 1'b0;
    last = 32'h0;
    for (int n = 0; n < 65537; n++) begin
      last = $urandom;
      rd_in = last;
      step();
    end
    idle();
    rs1_addr_in = 5'd1;
    rs2_addr_in = 5'd0;
    #1;
    checks++;
    if (wr_count_out !== 16'd1) begin
      errors++;
      $display("FAIL wrap_count: got %h exp %h", wr_count_out, 16'd1);
    end
    checks++;
    if (rs1_out !== last) begin
      errors++;
      $display("FAIL wrap_x1: got %h exp %h", rs1_out, last);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
    mdl_cnt = 0;
    test_reset();
    test_basic();
    test_gated();
    test_hazard();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
